// File: rtl/tblink_rpc_rtl_pkg.sv
// Shared types and constants for the TBLink RPC invoke responder.
package tblink_rpc_rtl_pkg;

    // Responder control states.
    typedef enum logic [2:0] {
        HDR_MID,
        HDR_CID,
        HDR_LEN,
        PARAMS,
        DISCARD,
        DISPATCH,
        WAIT,
        SEND
    } state_t;

    // Response status codes.
    localparam logic [7:0] RSP_OK         = 8'd0;
    localparam logic [7:0] RSP_BAD_METHOD = 8'd1;
    localparam logic [7:0] RSP_BAD_LEN    = 8'd2;
    localparam logic [7:0] RSP_TIMEOUT    = 8'd3;

    // Request frame header: method_id, call_id, len.
    localparam int FRAME_HDR_BYTES = 3;

    // Registered control outputs implied by a state: {req_ready, inv_valid, busy}.
    function automatic logic [2:0] state_outputs(input state_t s);
        logic [2:0] o;
        case (s)
            HDR_MID:  o = 3'b100;
            HDR_CID,
            HDR_LEN,
            PARAMS,
            DISCARD:  o = 3'b101;
            DISPATCH: o = 3'b011;
            default:  o = 3'b001;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tblink_rpc_rsp_serializer.sv
// Response frame serializer: call_id, status, then RET_BYTES return bytes, LSB first.
module tblink_rpc_rsp_serializer
    import tblink_rpc_rtl_pkg::*;
#(
    parameter int RET_BYTES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [7:0]             call_id,
    input  logic [7:0]             status,
    input  logic [8*RET_BYTES-1:0] ret,
    output logic [7:0]             rsp_dat,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_last,
    output logic                   done
);

    localparam int RSP_BYTES = 2 + RET_BYTES;
    localparam int IDX_W     = $clog2(RSP_BYTES + 1);

    logic [8*RSP_BYTES-1:0] frame;
    logic [IDX_W-1:0]       idx;

    // The byte on the wire is always the bottom of the shift register.
    assign rsp_dat = frame[7:0];
    assign done    = rsp_valid & rsp_ready & rsp_last;

    // Load a whole frame, then shift one byte out per accepted handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame     <= '0;
            idx       <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end else if (load) begin
            frame     <= {ret, status, call_id};
            idx       <= '0;
            rsp_valid <= 1'b1;
            rsp_last  <= (RSP_BYTES == 1);
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_last) begin
                frame     <= '0;
                idx       <= '0;
                rsp_valid <= 1'b0;
                rsp_last  <= 1'b0;
            end else begin
                frame    <= frame >> 8;
                idx      <= idx + IDX_W'(1);
                rsp_last <= (idx == IDX_W'(RSP_BYTES - 2));
            end
        end
    end

endmodule

// File: rtl/tblink_rpc_invoke_responder.sv
// TBLink invoke responder: de-frames requests, dispatches one call, returns a response frame.
module tblink_rpc_invoke_responder
    import tblink_rpc_rtl_pkg::*;
#(
    parameter int MAX_PARAM_BYTES = 8,
    parameter int RET_BYTES       = 4,
    parameter int NUM_METHODS     = 16,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [7:0]                   req_dat,
    input  logic                         req_valid,
    output logic                         req_ready,
    output logic                         inv_valid,
    input  logic                         inv_ready,
    output logic [7:0]                   inv_method,
    output logic [7:0]                   inv_call_id,
    output logic [7:0]                   inv_nbytes,
    output logic [8*MAX_PARAM_BYTES-1:0] inv_params,
    input  logic                         cmp_valid,
    input  logic [8*RET_BYTES-1:0]       cmp_ret,
    output logic [7:0]                   rsp_dat,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_last,
    output logic                         busy
);

    localparam int          PIDX_W   = $clog2(MAX_PARAM_BYTES + 1);
    localparam logic [7:0]  MAX_LEN  = 8'(MAX_PARAM_BYTES);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t                 state;
    logic [7:0]             method_id;
    logic [7:0]             call_id;
    logic [7:0]             status_r;
    logic [PIDX_W-1:0]      pidx;
    logic [7:0]             disc_cnt;
    logic [31:0]            tmo_cnt;

    logic                   req_acc;
    logic [7:0]             len_status;
    logic                   timeout_hit;
    logic                   ser_load;
    logic [7:0]             ser_status;
    logic [8*RET_BYTES-1:0] ser_ret;
    logic                   ser_done;

    assign req_acc     = req_valid & req_ready;
    assign inv_method  = method_id;
    assign inv_call_id = call_id;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT) && (tmo_cnt == TMO_LAST);

    // Validate the header: an oversize length outranks an unknown method.
    always_comb begin
        len_status = RSP_OK;
        if (req_dat > MAX_LEN) begin
            len_status = RSP_BAD_LEN;
        end else if ({1'b0, method_id} >= 9'(NUM_METHODS)) begin
            len_status = RSP_BAD_METHOD;
        end
    end

    // Decide when a response frame is loaded, so its first byte appears the next cycle.
    always_comb begin
        ser_load   = 1'b0;
        ser_status = RSP_OK;
        ser_ret    = '0;
        case (state)
            HDR_LEN: begin
                if (req_acc && (len_status != RSP_OK) && (req_dat == 8'd0)) begin
                    ser_load   = 1'b1;
                    ser_status = len_status;
                end
            end
            DISCARD: begin
                if (req_acc && (disc_cnt == 8'd1)) begin
                    ser_load   = 1'b1;
                    ser_status = status_r;
                end
            end
            WAIT: begin
                if (cmp_valid) begin
                    ser_load   = 1'b1;
                    ser_status = RSP_OK;
                    ser_ret    = cmp_ret;
                end else if (timeout_hit) begin
                    ser_load   = 1'b1;
                    ser_status = RSP_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Main control FSM with registered handshake/busy outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                       <= HDR_MID;
            {req_ready, inv_valid, busy} <= state_outputs(HDR_MID);
            method_id                   <= '0;
            call_id                     <= '0;
            inv_nbytes                  <= '0;
            inv_params                  <= '0;
            status_r                    <= RSP_OK;
            pidx                        <= '0;
            disc_cnt                    <= '0;
            tmo_cnt                     <= '0;
        end else begin
            case (state)
                HDR_MID: begin
                    if (req_acc) begin
                        method_id                   <= req_dat;
                        inv_params                  <= '0;
                        state                       <= HDR_CID;
                        {req_ready, inv_valid, busy} <= state_outputs(HDR_CID);
                    end
                end
                HDR_CID: begin
                    if (req_acc) begin
                        call_id                     <= req_dat;
                        state                       <= HDR_LEN;
                        {req_ready, inv_valid, busy} <= state_outputs(HDR_LEN);
                    end
                end
                HDR_LEN: begin
                    if (req_acc) begin
                        inv_nbytes <= req_dat;
                        status_r   <= len_status;
                        pidx       <= '0;
                        if (len_status != RSP_OK) begin
                            if (req_dat == 8'd0) begin
                                state                       <= SEND;
                                {req_ready, inv_valid, busy} <= state_outputs(SEND);
                            end else begin
                                disc_cnt                    <= req_dat;
                                state                       <= DISCARD;
                                {req_ready, inv_valid, busy} <= state_outputs(DISCARD);
                            end
                        end else if (req_dat == 8'd0) begin
                            state                       <= DISPATCH;
                            {req_ready, inv_valid, busy} <= state_outputs(DISPATCH);
                        end else begin
                            state                       <= PARAMS;
                            {req_ready, inv_valid, busy} <= state_outputs(PARAMS);
                        end
                    end
                end
                PARAMS: begin
                    if (req_acc) begin
                        for (int k = 0; k < MAX_PARAM_BYTES; k++) begin
                            if (pidx == PIDX_W'(k)) begin
                                inv_params[8*k +: 8] <= req_dat;
                            end
                        end
                        pidx <= pidx + PIDX_W'(1);
                        if ((8'(pidx) + 8'd1) == inv_nbytes) begin
                            state                       <= DISPATCH;
                            {req_ready, inv_valid, busy} <= state_outputs(DISPATCH);
                        end
                    end
                end
                DISCARD: begin
                    if (req_acc) begin
                        disc_cnt <= disc_cnt - 8'd1;
                        if (disc_cnt == 8'd1) begin
                            state                       <= SEND;
                            {req_ready, inv_valid, busy} <= state_outputs(SEND);
                        end
                    end
                end
                DISPATCH: begin
                    if (inv_ready) begin
                        tmo_cnt                     <= '0;
                        state                       <= WAIT;
                        {req_ready, inv_valid, busy} <= state_outputs(WAIT);
                    end
                end
                WAIT: begin
                    if (ser_load) begin
                        state                       <= SEND;
                        {req_ready, inv_valid, busy} <= state_outputs(SEND);
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                SEND: begin
                    if (ser_done) begin
                        state                       <= HDR_MID;
                        {req_ready, inv_valid, busy} <= state_outputs(HDR_MID);
                    end
                end
                default: begin
                    state                       <= HDR_MID;
                    {req_ready, inv_valid, busy} <= state_outputs(HDR_MID);
                end
            endcase
        end
    end

    tblink_rpc_rsp_serializer #(
        .RET_BYTES (RET_BYTES)
    ) u_ser (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ser_load),
        .call_id   (call_id),
        .status    (ser_status),
        .ret       (ser_ret),
        .rsp_dat   (rsp_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_last  (rsp_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_tblink_rpc_invoke_responder.sv
// Directed plus randomized bench for the TBLink invoke responder.
module tb_tblink_rpc_invoke_responder;

    localparam int MAXP = 8;
    localparam int RETB = 4;
    localparam int NUMM = 16;
    localparam int TMO  = 10;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [7:0]            req_dat = '0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  inv_valid;
    logic                  inv_ready = 1'b0;
    logic [7:0]            inv_method;
    logic [7:0]            inv_call_id;
    logic [7:0]            inv_nbytes;
    logic [8*MAXP-1:0]     inv_params;
    logic                  cmp_valid = 1'b0;
    logic [8*RETB-1:0]     cmp_ret = '0;
    logic [7:0]            rsp_dat;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic                  rsp_last;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int inv_hi_cnt = 0;

    always #5 clock = ~clock;

    tblink_rpc_invoke_responder #(
        .MAX_PARAM_BYTES (MAXP),
        .RET_BYTES       (RETB),
        .NUM_METHODS     (NUMM),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_dat     (req_dat),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .inv_valid   (inv_valid),
        .inv_ready   (inv_ready),
        .inv_method  (inv_method),
        .inv_call_id (inv_call_id),
        .inv_nbytes  (inv_nbytes),
        .inv_params  (inv_params),
        .cmp_valid   (cmp_valid),
        .cmp_ret     (cmp_ret),
        .rsp_dat     (rsp_dat),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_last    (rsp_last),
        .busy        (busy)
    );

    // Count cycles on which a dispatch is offered.
    always @(negedge clock) if (inv_valid) inv_hi_cnt++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference status for a call, straight from the frame rules.
    function automatic logic [7:0] model_status(input int mid, input int len, input bit timed_out);
        if (len > MAXP)   return 8'd2;
        if (mid >= NUMM)  return 8'd1;
        if (timed_out)    return 8'd3;
        return 8'd0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit acc;
        int n;
        repeat ($urandom_range(maxgap, 0)) @(negedge clock);
        req_dat   = b;
        req_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = req_ready;
            @(negedge clock);
            n++;
        end
        req_valid = 1'b0;
        if (!acc) check("req_accept", 64'(acc), 64'd1);
    endtask

    task automatic collect(input logic [7:0] exp_rsp[$], input bit toggle);
        int  got;
        int  n;
        bit  tog;
        bit  done;
        got  = 0;
        n    = 0;
        tog  = 1'b1;
        done = 1'b0;
        while (!done && n < 200) begin
            rsp_ready = toggle ? tog : 1'b1;
            tog = ~tog;
            if (rsp_valid && rsp_ready) begin
                if (got < exp_rsp.size()) begin
                    check($sformatf("rsp_byte%0d", got), 64'(rsp_dat), 64'(exp_rsp[got]));
                    check($sformatf("rsp_last%0d", got), 64'(rsp_last), 64'(got == exp_rsp.size() - 1));
                end
                got++;
                done = rsp_last;
            end
            @(negedge clock);
            n++;
        end
        rsp_ready = 1'b0;
        check("rsp_count", 64'(got), 64'(exp_rsp.size()));
        check("busy_after_rsp", 64'(busy), 64'd0);
    endtask

    // One complete call: request frame, optional dispatch/completion, response check.
    task automatic do_call(input logic [7:0] mid, input logic [7:0] cid, input logic [7:0] params[$],
                           input int cmp_delay, input logic [31:0] ret, input int maxgap,
                           input bit toggle, input bit early_cmp);
        logic [7:0]  len;
        logic [7:0]  st;
        logic [63:0] exp_params;
        logic [7:0]  exp_rsp[$];
        int          n;
        int          inv_before;
        len = 8'(params.size());
        st  = model_status(mid, len, cmp_delay < 0);
        exp_params = '0;
        for (int i = 0; i < params.size() && i < MAXP; i++) exp_params[8*i +: 8] = params[i];
        inv_before = inv_hi_cnt;
        send_byte(mid, maxgap);
        send_byte(cid, maxgap);
        send_byte(len, maxgap);
        foreach (params[i]) send_byte(params[i], maxgap);
        if (st == 8'd0 || st == 8'd3) begin
            check("inv_valid_latency", 64'(inv_valid), 64'd1);
            check("inv_method", 64'(inv_method), 64'(mid));
            check("inv_call_id", 64'(inv_call_id), 64'(cid));
            check("inv_nbytes", 64'(inv_nbytes), 64'(len));
            check("inv_params", 64'(inv_params), exp_params);
            repeat ($urandom_range(2, 0)) @(negedge clock);
            check("inv_hold", 64'({inv_valid, inv_params}), {1'b1, exp_params});
            inv_ready = 1'b1;
            cmp_valid = early_cmp;
            cmp_ret   = ~ret;
            @(negedge clock);
            inv_ready = 1'b0;
            cmp_valid = 1'b0;
            if (cmp_delay >= 0) begin
                repeat (cmp_delay) @(negedge clock);
                cmp_valid = 1'b1;
                cmp_ret   = ret;
                @(negedge clock);
                cmp_valid = 1'b0;
                check("rsp_valid_latency", 64'(rsp_valid), 64'd1);
            end else begin
                n = 0;
                while (!rsp_valid && n < 100) begin
                    n++;
                    @(negedge clock);
                end
                check("wait_cycles", 64'(n), 64'(TMO));
            end
        end else begin
            check("rsp_valid_after_err", 64'(rsp_valid), 64'd1);
            check("no_dispatch", 64'(inv_hi_cnt - inv_before), 64'd0);
        end
        exp_rsp = {cid, st};
        for (int b = 0; b < RETB; b++) exp_rsp.push_back((st == 8'd0) ? ret[8*b +: 8] : 8'd0);
        collect(exp_rsp, toggle);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] m;
        int         l;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_inv_valid", 64'(inv_valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_last", 64'(rsp_last), 64'd0);
        check("rst_inv_params", 64'(inv_params), 64'd0);
        check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic call, completion 5 cycles after dispatch
        q = {8'hAA, 8'hBB, 8'hCC};
        do_call(8'd2, 8'h11, q, 5, 32'h01020304, 0, 1'b0, 1'b0);

        // Completion strobe in the dispatch handshake cycle must be ignored
        q = {8'h5A};
        do_call(8'd5, 8'h22, q, 2, 32'hCAFE0001, 0, 1'b0, 1'b1);

        // Unknown method with parameters, then with no parameters
        q = {8'h01, 8'h02};
        do_call(8'd20, 8'h33, q, 0, 32'h0, 0, 1'b0, 1'b0);
        q = {};
        do_call(8'h40, 8'h34, q, 0, 32'h0, 0, 1'b0, 1'b0);

        // Oversize length, plain and combined with a bad method
        q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        do_call(8'd3, 8'h35, q, 0, 32'h0, 0, 1'b0, 1'b0);
        do_call(8'd20, 8'h36, q, 0, 32'h0, 0, 1'b0, 1'b0);

        // Maximum length and zero length well-formed calls
        q = {8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        do_call(8'd15, 8'h37, q, 1, 32'h89ABCDEF, 0, 1'b0, 1'b0);
        q = {};
        do_call(8'd0, 8'h38, q, 0, 32'h55AA55AA, 0, 1'b0, 1'b0);

        // Timeout, then a late completion that must be dropped
        q = {8'h77};
        do_call(8'd1, 8'h44, q, -1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        cmp_valid = 1'b1;
        cmp_ret   = 32'h12345678;
        @(negedge clock);
        cmp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_cmp_busy", 64'(busy), 64'd0);
            check("late_cmp_rsp_valid", 64'(rsp_valid), 64'd0);
            @(negedge clock);
        end

        // Asynchronous reset in the middle of a parameter stream
        send_byte(8'd2, 0);
        send_byte(8'h55, 0);
        send_byte(8'd4, 0);
        send_byte(8'hE1, 0);
        send_byte(8'hE2, 0);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_inv_params", 64'(inv_params), 64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        q = {8'h0F, 8'hF0};
        do_call(8'd9, 8'h66, q, 3, 32'hA5A5_0102, 0, 1'b0, 1'b0);

        // Randomized back-to-back calls with gaps and response back-pressure
        for (int c = 0; c < 100; c++) begin
            q = {};
            l = $urandom_range(10, 0);
            for (int i = 0; i < l; i++) q.push_back(8'($urandom));
            if ($urandom_range(7, 0) == 0) m = 8'(16 + $urandom_range(200, 0));
            else                           m = 8'($urandom_range(15, 0));
            do_call(m, 8'(c), q, $urandom_range(6, 0), $urandom, 2, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tblink_rpc_invoke_responder.md
Name: tblink_rpc_invoke_responder

Overview:
- Synthesizable RTL endpoint that answers TBLink invoke requests on the hardware side. The testbench issues the calls; this block receives them.
- It de-frames invoke request byte streams, dispatches one call at a time to a user method port, waits for completion and serializes a response frame back.
- It sits between the transport byte channel and user RTL that implements interface methods.

Parameters:
- MAX_PARAM_BYTES, 8: maximum parameter payload bytes per call; the legal range is 1..32.
- RET_BYTES, 4: return-value bytes carried in every response frame.
- NUM_METHODS, 16: method ids 0..NUM_METHODS-1 are valid.
- TIMEOUT_CYCLES, 0: maximum cycles spent waiting for completion; 0 disables the timeout.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  reset, asynchronous and active-low.
- req_dat  in  8  request byte.
- req_valid  in  1  request byte valid.
- req_ready  out  1  request byte accepted when req_valid&&req_ready.
- inv_valid  out  1  dispatch request to user logic.
- inv_ready  in  1  user accepts dispatch.
- inv_method  out  8  method id.
- inv_call_id  out  8  call id.
- inv_nbytes  out  8  parameter byte count.
- inv_params  out  8*MAX_PARAM_BYTES  packed parameters; byte k is at [8k+:8].
- cmp_valid  in  1  user completion strobe (single cycle).
- cmp_ret  in  8*RET_BYTES  return value, sampled with cmp_valid.
- rsp_dat  out  8  response byte.
- rsp_valid  out  1  response byte valid.
- rsp_ready  in  1  response byte consumed.
- rsp_last  out  1  marks the final response byte.
- busy  out  1  high whenever state != HDR_MID.

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State=HDR_MID. Captured fields and inv_params are zeroed. Asserting reset mid-frame aborts everything immediately; no partial response is emitted.
- Request frame: method_id, call_id, len, then len parameter bytes.
- Response frame: call_id, status, then RET_BYTES return bytes, LSB first. rsp_last is high on the final byte.
- Status codes: 0 OK, 1 BAD_METHOD, 2 BAD_LEN, 3 TIMEOUT. Error responses carry zero return bytes of value (the bytes are still sent).
- req_ready=1 only in HDR_MID, HDR_CID, HDR_LEN, PARAMS and DISCARD; it is 0 in all other states.
- State transitions:
  - HDR_MID --accept--> HDR_CID. Captures the method id. inv_params is cleared on this accept.
  - HDR_CID --accept--> HDR_LEN. Captures the call id.
  - HDR_LEN --accept-->:
    - len > MAX_PARAM_BYTES: go to DISCARD with status 2; or, if len==0, go to SEND.
    - else if method_id >= NUM_METHODS: DISCARD with status 1 (SEND if len==0).
    - else len==0: DISPATCH.
    - else: PARAMS.
  - The BAD_LEN check has priority over the BAD_METHOD check.
  - PARAMS: the byte index counter increments per accept. The last byte goes to DISPATCH on the next cycle.
  - DISCARD: consumes the remaining len bytes, then goes to SEND. Nothing is dispatched.
  - DISPATCH: inv_valid=1. inv_method, inv_call_id, inv_nbytes and inv_params are held stable until inv_ready. On the handshake, go to WAIT.
  - WAIT: cmp_valid is sampled only in this state; a strobe in the DISPATCH handshake cycle is ignored. On cmp_valid, latch cmp_ret, set status 0 and go to SEND.
  - WAIT timeout: the timeout counter starts at 0 on entry. With TIMEOUT_CYCLES>0, when the counter reaches TIMEOUT_CYCLES without cmp_valid, set status 3, zero the return value and go to SEND.
  - SEND: rsp_valid=1. The byte index advances on each rsp_ready. After the final byte, go to HDR_MID.
- Latency, zero-stall source/sink: the last request byte accept is followed by inv_valid on the next cycle. cmp_valid is followed by the first rsp_valid on the next cycle.
- Response length is 2+RET_BYTES bytes, always.
- A cmp_valid arriving outside WAIT is dropped, including late completions after a timeout.
- Only one call is outstanding at a time. Back-pressure on rsp_ready stalls the block indefinitely; no request bytes are accepted meanwhile.
- Counter widths: param index is clog2(MAX_PARAM_BYTES+1). Discard counter is 8 bits. Timeout counter is 32 bits and saturating.

Decomposition:
- Package tblink_rpc_rtl_pkg holds:
  - the state enum;
  - status constants (RSP_OK, RSP_BAD_METHOD, RSP_BAD_LEN, RSP_TIMEOUT);
  - the frame header length constant (3).
- One sub-module, tblink_rpc_rsp_serializer: loads call_id, status and ret, then shifts bytes out with valid/ready and last.

Test Plan:
- Method 2, call 0x11, len 3, params AA BB CC; inv_ready high; cmp after 5 cycles with ret 0x01020304 -> inv_params[23:0]=CCBBAA (upper bytes 0), inv_nbytes=3; response bytes 11 00 04 03 02 01 with last on 01.
- Method 20 (>=16), len 2 -> both bytes consumed, inv_valid never asserts; response xx 01 00 00 00 00.
- len 9 with MAX=8 -> 9 bytes discarded; status 02; a following frame is processed normally.
- TIMEOUT_CYCLES=10, no cmp -> response status 03 after 10 WAIT cycles; a cmp_valid 3 cycles later is ignored and busy stays 0.
- Random req_valid gaps plus rsp_ready toggled every other cycle; 100 back-to-back calls -> every call_id is echoed in order and no byte is lost or duplicated.
- reset_n pulsed low during PARAMS -> outputs return to reset values asynchronously; the next full frame gives a correct dispatch and response.
